// File: rtl/booth_r8_datapath_if.sv
// Handshake bundle between the radix-8 Booth control FSM (master) and its
// arithmetic datapath (slave).
//   si            micro-op select, FSM -> datapath
//   count         step-count enable, only meaningful with the Shift micro-op
//   multiplicand  operand M, sampled on Load
//   multiplier    operand Q, sampled on Load
//   b             Booth window {Q[2:0], Q_1}, datapath -> FSM
//   done          one-cycle pulse, all steps retired
//   busy          high from the Load cycle until the Done cycle
//   product       signed 2N-bit result, held until the next Done
interface booth_r8_datapath_if #(
  parameter int unsigned N = 12
);
  logic [3:0]     si;
  logic           count;
  logic [N-1:0]   multiplicand;
  logic [N-1:0]   multiplier;
  logic [3:0]     b;
  logic           done;
  logic           busy;
  logic [2*N-1:0] product;

  modport master (
    output si, count, multiplicand, multiplier,
    input  b, done, busy, product
  );

  modport slave (
    input  si, count, multiplicand, multiplier,
    output b, done, busy, product
  );
endinterface

// File: rtl/booth_r8_datapath.sv
// Radix-8 Booth multiplier datapath. Executes one control-FSM micro-op per
// cycle on an {A, Q, Q_1} shift pair and returns the Booth window and Done
// flag to the FSM. The finished signed 2N-bit product is held in a register
// until the next Done.
//   clk   rising-edge clock
//   rst   asynchronous active-high reset, clears all state
//   bus   slave side of booth_r8_datapath_if (si/count/operands in,
//         b/done/busy/product out)
// N must be a multiple of 3; the multiply takes K = N/3 add/shift steps.
module booth_r8_datapath #(
  parameter int unsigned N = 12
) (
  input logic               clk,
  input logic               rst,
  booth_r8_datapath_if.slave bus
);

  localparam int unsigned K  = N / 3;
  localparam int unsigned CW = $clog2(K + 1);
  // Three guard bits: the largest step adds 4M, which needs two extra bits
  // beyond the sign, and the arithmetic shift needs one more.
  localparam int unsigned AW = N + 3;

  typedef enum logic [3:0] {
    OpNop    = 4'b0000,
    OpAddM   = 4'b0001,
    OpSubM   = 4'b0010,
    OpLoad   = 4'b0011,
    OpShift  = 4'b0100,
    OpAdd2M  = 4'b0101,
    OpSub2M  = 4'b0110,
    OpAdd3M  = 4'b0111,
    OpSub3M  = 4'b1000,
    OpSub4M  = 4'b1001,
    OpAdd4M  = 4'b1010
  } op_e;

  // State registers
  logic signed [AW-1:0] a_q, a_d;
  logic [N-1:0]         q_q, q_d;
  logic                 q1_q, q1_d;
  logic [N-1:0]         m_q, m_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic [2*N-1:0]       product_q, product_d;

  // Multiplicand multiples, all sign-extended to the accumulator width
  logic [AW-1:0] m1;
  logic [AW-1:0] m2;
  logic [AW-1:0] m3;
  logic [AW-1:0] m4;

  op_e  op;
  logic done;

  assign op = op_e'(bus.si);

  assign m1 = {{3{m_q[N-1]}}, m_q};
  assign m2 = m1 << 1;
  assign m4 = m1 << 2;
  assign m3 = m1 + m2;

  assign done = busy_q && (cnt_q == CW'(K));

  // Next-state logic. Priority: Load, then Done, then busy-gated micro-ops.
  always_comb begin
    a_d       = a_q;
    q_d       = q_q;
    q1_d      = q1_q;
    m_d       = m_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    product_d = product_q;

    if (op == OpLoad) begin
      // Accepted at any time; a Load in the Done cycle discards that result.
      a_d    = '0;
      q_d    = bus.multiplier;
      q1_d   = 1'b0;
      m_d    = bus.multiplicand;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (done) begin
      // The FSM may still issue an op for the stale window here; drop it.
      product_d = {a_q[N-1:0], q_q};
      busy_d    = 1'b0;
    end else if (busy_q) begin
      case (op)
        OpAddM:  a_d = a_q + m1;
        OpSubM:  a_d = a_q - m1;
        OpAdd2M: a_d = a_q + m2;
        OpSub2M: a_d = a_q - m2;
        OpAdd3M: a_d = a_q + m3;
        OpSub3M: a_d = a_q - m3;
        OpAdd4M: a_d = a_q + m4;
        OpSub4M: a_d = a_q - m4;
        OpShift: begin
          a_d  = a_q >>> 3;
          q_d  = {a_q[2:0], q_q[N-1:3]};
          q1_d = q_q[2];
          if (bus.count) begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q       <= '0;
      q_q       <= '0;
      q1_q      <= 1'b0;
      m_q       <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      product_q <= '0;
    end else begin
      a_q       <= a_d;
      q_q       <= q_d;
      q1_q      <= q1_d;
      m_q       <= m_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      product_q <= product_d;
    end
  end

  assign bus.b       = {q_q[2:0], q1_q};
  assign bus.done    = done;
  assign bus.busy    = busy_q;
  assign bus.product = product_q;

endmodule
